// File: rtl/riscv_defs.sv
// Shared definitions for the fetch slice: datapath widths, FSM encoding and
// the {pc, instr} record carried from fetch to decode.
package riscv_defs;

  localparam int                NB_ADDR      = 32;
  localparam int                NB_INSTR     = 32;
  localparam logic [NB_ADDR-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_TRAP
  } fetch_state_t;

  typedef struct packed {
    logic [NB_ADDR-1:0]  pc;
    logic [NB_INSTR-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// The head output reads zero whenever the buffer is empty.
module fetch_fifo
  import riscv_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t entry_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses <= so all flops sample pre-edge values together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the empty gate on head_o hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, drives imem, buffers {pc, instr}
// for decode and takes redirects; a misaligned redirect target traps fetch.
module ifetch
  import riscv_defs::*;
#(
  parameter logic [NB_ADDR-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic [NB_ADDR-1:0]  imem_pc,
  input  logic [NB_INSTR-1:0] imem_instruction,
  input  logic                redirect_valid,
  input  logic [NB_ADDR-1:0]  redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [NB_ADDR-1:0]  dec_pc,
  output logic [NB_INSTR-1:0] dec_instr,
  output logic                fetch_misaligned,
  output logic [NB_ADDR-1:0]  misaligned_addr
);

  fetch_state_t       state_q, state_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_ADDR-1:0] mis_addr_q, mis_addr_d;
  logic               redirect_ok, misalign;
  logic               flush, push, pop, full, empty;
  fetch_entry_t       head;

  // Redirects are ignored once trapped; only reset leaves TRAP.
  assign redirect_ok = redirect_valid && (state_q != FETCH_TRAP);
  assign misalign    = redirect_ok && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: if (misalign) state_d = FETCH_TRAP;
                  else if (fetch_en) state_d = FETCH_RUN;
      FETCH_RUN:  if (misalign) state_d = FETCH_TRAP;
                  else if (!fetch_en) state_d = FETCH_IDLE;
      FETCH_TRAP: state_d = FETCH_TRAP;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    flush      = redirect_ok;
    pop        = dec_valid && dec_ready && !redirect_ok;
    push       = (state_q == FETCH_RUN) && !redirect_ok && (!full || pop);
    pc_d       = pc_q;
    mis_addr_d = mis_addr_q;
    if (misalign)         mis_addr_d = redirect_pc;
    else if (redirect_ok) pc_d = redirect_pc;
    else if (push)        pc_d = pc_q + 32'd4;
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i ('{pc: pc_q, instr: imem_instruction}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign imem_pc          = pc_q;
  assign dec_valid        = !empty;
  assign dec_pc           = head.pc;
  assign dec_instr        = head.instr;
  assign fetch_misaligned = (state_q == FETCH_TRAP);
  assign misaligned_addr  = mis_addr_q;

endmodule
